// File: rtl/weight_reg_bank_if.sv
// Load / swap / read bundle for the double-buffered weight register bank.
// Optional macro: WBANK_NZ_COUNT_EN adds the nz_count_o member.
interface weight_reg_bank_if #(
  parameter int F_WIDTH = 8,
  parameter int DEPTH   = 9
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic                      ld_valid_i;
  logic signed [F_WIDTH-1:0] ld_weight_i;
  logic                      ld_ready_o;
  logic                      swap_i;
  logic [ADDR_W-1:0]         rd_addr_i;
  logic signed [F_WIDTH-1:0] f_weight_o;
  logic                      shadow_full_o;
  logic                      active_valid_o;
`ifdef WBANK_NZ_COUNT_EN
  logic [CNT_W-1:0]          nz_count_o;

  // Upstream side: supplies weights, swap requests and read addresses
  modport master (
    output ld_valid_i, ld_weight_i, swap_i, rd_addr_i,
    input  ld_ready_o, f_weight_o, shadow_full_o, active_valid_o, nz_count_o
  );

  // Bank side
  modport slave (
    input  ld_valid_i, ld_weight_i, swap_i, rd_addr_i,
    output ld_ready_o, f_weight_o, shadow_full_o, active_valid_o, nz_count_o
  );
`else
  // Upstream side: supplies weights, swap requests and read addresses
  modport master (
    output ld_valid_i, ld_weight_i, swap_i, rd_addr_i,
    input  ld_ready_o, f_weight_o, shadow_full_o, active_valid_o
  );

  // Bank side
  modport slave (
    input  ld_valid_i, ld_weight_i, swap_i, rd_addr_i,
    output ld_ready_o, f_weight_o, shadow_full_o, active_valid_o
  );
`endif
endinterface

// File: rtl/weight_reg_bank.sv
// Double-buffered signed weight register bank. Weights stream into the
// shadow bank; a swap copies the full shadow bank into the active bank,
// which serves registered random-access reads.
// Optional macro: WBANK_NZ_COUNT_EN enables the non-zero weight counter.
module weight_reg_bank #(
  parameter int F_WIDTH = 8,
  parameter int DEPTH   = 9
) (
  input  logic             clk_i,
  input  logic             wbank_rst_i,
  weight_reg_bank_if.slave wb
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [ADDR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic signed [F_WIDTH-1:0] shadow_q [DEPTH];
  logic signed [F_WIDTH-1:0] shadow_d [DEPTH];
  logic signed [F_WIDTH-1:0] active_q [DEPTH];
  logic signed [F_WIDTH-1:0] active_d [DEPTH];
  logic                      active_valid_q, active_valid_d;
  logic signed [F_WIDTH-1:0] f_weight_q, f_weight_d;
  logic                      accept;
  logic                      do_swap;
`ifdef WBANK_NZ_COUNT_EN
  logic [CNT_W-1:0]          nz_shadow_q, nz_shadow_d;
  logic [CNT_W-1:0]          nz_count_q, nz_count_d;
`endif

  // Handshake and swap qualification come straight from the registered state
  assign accept  = wb.ld_valid_i && (state_q == ST_LOAD);
  assign do_swap = wb.swap_i && (state_q == ST_FULL);

  // Next-state logic: shadow writes, pointer, FSM transitions, swap copy, read mux
  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    shadow_d       = shadow_q;
    active_d       = active_q;
    active_valid_d = active_valid_q;
    f_weight_d     = '0;
`ifdef WBANK_NZ_COUNT_EN
    nz_shadow_d    = nz_shadow_q;
    nz_count_d     = nz_count_q;
`endif

    if (accept) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_ptr_q == ADDR_W'(i)) begin
          shadow_d[i] = wb.ld_weight_i;
        end
      end
`ifdef WBANK_NZ_COUNT_EN
      // The first weight of a sequence restarts the count
      nz_shadow_d = ((wr_ptr_q == '0) ? '0 : nz_shadow_q) + CNT_W'(wb.ld_weight_i != '0);
`endif
      if (wr_ptr_q == ADDR_W'(DEPTH - 1)) begin
        wr_ptr_d = '0;
        state_d  = ST_FULL;
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end

    if (do_swap) begin
      active_d       = shadow_q;
      active_valid_d = 1'b1;
      state_d        = ST_LOAD;
      wr_ptr_d       = '0;
`ifdef WBANK_NZ_COUNT_EN
      nz_count_d     = nz_shadow_q;
`endif
    end

    // Read uses the pre-edge active bank, so a read on the swap edge sees old data;
    // out-of-range addresses fall through to zero
    if (active_valid_q) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wb.rd_addr_i == ADDR_W'(i)) begin
          f_weight_d = active_q[i];
        end
      end
    end
  end

  // State register; reset clears both banks and overrides any load or swap
  always_ff @(posedge clk_i) begin
    if (wbank_rst_i) begin
      state_q        <= ST_LOAD;
      wr_ptr_q       <= '0;
      active_valid_q <= 1'b0;
      f_weight_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
`ifdef WBANK_NZ_COUNT_EN
      nz_shadow_q    <= '0;
      nz_count_q     <= '0;
`endif
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      active_valid_q <= active_valid_d;
      f_weight_q     <= f_weight_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
`ifdef WBANK_NZ_COUNT_EN
      nz_shadow_q    <= nz_shadow_d;
      nz_count_q     <= nz_count_d;
`endif
    end
  end

  assign wb.ld_ready_o     = (state_q == ST_LOAD);
  assign wb.shadow_full_o  = (state_q == ST_FULL);
  assign wb.active_valid_o = active_valid_q;
  assign wb.f_weight_o     = f_weight_q;
`ifdef WBANK_NZ_COUNT_EN
  assign wb.nz_count_o     = nz_count_q;
`endif

endmodule

// File: tb/tb_weight_reg_bank.sv
// Directed bench for weight_reg_bank: load/swap/read, handshake corners,
// mid-sequence reset and (with WBANK_NZ_COUNT_EN) the non-zero counter.
module tb_weight_reg_bank;
  localparam int F_WIDTH = 8;
  localparam int DEPTH   = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  weight_reg_bank_if #(.F_WIDTH(F_WIDTH), .DEPTH(DEPTH)) wb ();

  weight_reg_bank #(.F_WIDTH(F_WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .wbank_rst_i (rst),
    .wb          (wb)
  );

  typedef struct {
    logic [3:0] addr;
    bit         in_range;
  } rd_vec_t;

  rd_vec_t rd_tab [11];
  int n_pass  = 0;
  int n_total = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
      $display("ok   %s: got %0d", name, act);
    end else begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load(input int w);
    wb.ld_valid_i  = 1'b1;
    wb.ld_weight_i = 8'(w);
    step();
    wb.ld_valid_i  = 1'b0;
  endtask

  task automatic do_swap();
    wb.swap_i = 1'b1;
    step();
    wb.swap_i = 1'b0;
  endtask

  // Active bank expected to hold base+1 .. base+DEPTH
  task automatic run_reads(input int base, input string tag);
    for (int i = 0; i < 11; i++) begin
      int exp_v;
      wb.rd_addr_i = rd_tab[i].addr;
      step();
      exp_v = rd_tab[i].in_range ? base + int'(rd_tab[i].addr) + 1 : 0;
      check($sformatf("%s_rd_addr%0d", tag, rd_tab[i].addr), $signed(wb.f_weight_o), exp_v);
    end
  endtask

  initial begin
    int set_b [DEPTH];
    int set_nz [DEPTH];
    set_b  = '{-128, 0, 0, 5, 0, 0, 0, 0, 127};
    set_nz = '{0, 3, 0, -1, 0, 0, 7, 0, 0};
    for (int i = 0; i < DEPTH; i++) begin
      rd_tab[i].addr     = 4'(i);
      rd_tab[i].in_range = 1'b1;
    end
    rd_tab[9].addr      = 4'd12;
    rd_tab[9].in_range  = 1'b0;
    rd_tab[10].addr     = 4'd15;
    rd_tab[10].in_range = 1'b0;

    wb.ld_valid_i  = 1'b0;
    wb.ld_weight_i = '0;
    wb.swap_i      = 1'b0;
    wb.rd_addr_i   = '0;

    // Reset state
    step();
    step();
    check("rst_ld_ready", int'(wb.ld_ready_o), 1);
    check("rst_shadow_full", int'(wb.shadow_full_o), 0);
    check("rst_active_valid", int'(wb.active_valid_o), 0);
    check("rst_f_weight", $signed(wb.f_weight_o), 0);
`ifdef WBANK_NZ_COUNT_EN
    check("rst_nz_count", int'(wb.nz_count_o), 0);
`endif
    rst = 1'b0;

    // Load 1..8, then the 9th together with a swap request that must be ignored
    for (int i = 1; i <= 8; i++) load(i);
    check("pre9_ld_ready", int'(wb.ld_ready_o), 1);
    check("pre9_shadow_full", int'(wb.shadow_full_o), 0);
    wb.swap_i      = 1'b1;
    wb.ld_valid_i  = 1'b1;
    wb.ld_weight_i = 8'd9;
    step();
    wb.swap_i     = 1'b0;
    wb.ld_valid_i = 1'b0;
    check("load9_shadow_full", int'(wb.shadow_full_o), 1);
    check("load9_ld_ready", int'(wb.ld_ready_o), 0);
    check("same_cycle_swap_ignored", int'(wb.active_valid_o), 0);

    // Extra weight while FULL is refused; reads stay zero while nothing is active
    wb.rd_addr_i   = 4'd0;
    wb.ld_valid_i  = 1'b1;
    wb.ld_weight_i = 8'h7F;
    step();
    step();
    wb.ld_valid_i = 1'b0;
    check("full_ld_ready", int'(wb.ld_ready_o), 0);
    check("full_still_full", int'(wb.shadow_full_o), 1);
    check("inactive_read_zero", $signed(wb.f_weight_o), 0);

    do_swap();
    check("swap_active_valid", int'(wb.active_valid_o), 1);
    check("swap_ld_ready", int'(wb.ld_ready_o), 1);
    check("swap_shadow_full", int'(wb.shadow_full_o), 0);
    run_reads(0, "set1");

    // Second set with extremes; new sequence must start at index 0
    for (int i = 0; i < DEPTH; i++) load(set_b[i]);
    check("setb_shadow_full", int'(wb.shadow_full_o), 1);
    wb.rd_addr_i = 4'd0;
    step();
    check("setb_preswap_rd0", $signed(wb.f_weight_o), 1);
    do_swap();
    wb.rd_addr_i = 4'd0;
    step();
    check("setb_rd0", $signed(wb.f_weight_o), -128);
    wb.rd_addr_i = 4'd3;
    step();
    check("setb_rd3", $signed(wb.f_weight_o), 5);
    wb.rd_addr_i = 4'd8;
    step();
    check("setb_rd8", $signed(wb.f_weight_o), 127);
`ifdef WBANK_NZ_COUNT_EN
    check("setb_nz_count", int'(wb.nz_count_o), 3);
`endif

    // Load 10..18 while reading; active side must not change until swap
    for (int i = 10; i <= 18; i++) load(i);
    check("shadow_hidden_rd8", $signed(wb.f_weight_o), 127);
    wb.rd_addr_i = 4'd3;
    wb.swap_i    = 1'b1;
    step();
    wb.swap_i = 1'b0;
    check("swap_edge_rd3_old", $signed(wb.f_weight_o), 5);
    step();
    check("post_swap_rd3_new", $signed(wb.f_weight_o), 13);
    wb.rd_addr_i = 4'd12;
    step();
    check("rd_out_of_range", $signed(wb.f_weight_o), 0);

    // Reset in the middle of a load sequence
    wb.rd_addr_i = 4'd3;
    for (int i = 99; i <= 102; i++) load(i);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_ld_ready", int'(wb.ld_ready_o), 1);
    check("midrst_shadow_full", int'(wb.shadow_full_o), 0);
    check("midrst_active_valid", int'(wb.active_valid_o), 0);
    check("midrst_f_weight", $signed(wb.f_weight_o), 0);
`ifdef WBANK_NZ_COUNT_EN
    check("midrst_nz_count", int'(wb.nz_count_o), 0);
`endif
    step();
    check("midrst_read_zero", $signed(wb.f_weight_o), 0);
    for (int i = 21; i <= 28; i++) load(i);
    check("post_rst_8_not_full", int'(wb.shadow_full_o), 0);
    load(29);
    check("post_rst_9_full", int'(wb.shadow_full_o), 1);
    do_swap();
    run_reads(20, "set21");

`ifdef WBANK_NZ_COUNT_EN
    // Non-zero counter: zero until swap, then the count of the new set
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) load(set_nz[i]);
    check("nz_pre_swap", int'(wb.nz_count_o), 0);
    do_swap();
    check("nz_post_swap", int'(wb.nz_count_o), 3);
    wb.rd_addr_i = 4'd6;
    step();
    check("nz_rd6", $signed(wb.f_weight_o), 7);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/weight_reg_bank.md
WEIGHT_REG_BANK -- requirements
Module: weight_reg_bank

Interface
REQ-001 SHALL have parameter F_WIDTH, default 8, signed weight width in bits (>=2).
REQ-002 SHALL have parameter DEPTH, default 9, weights per bank (>=2); localparams ADDR_W=$clog2(DEPTH), CNT_W=$clog2(DEPTH+1).
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port wbank_rst_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port ld_valid_i  input  1  load weight present.
REQ-006 SHALL have port ld_weight_i  input  F_WIDTH signed  weight to load.
REQ-007 SHALL have port ld_ready_o  output  1  shadow bank accepts a load.
REQ-008 SHALL have port swap_i  input  1  request to promote shadow bank to active.
REQ-009 SHALL have port rd_addr_i  input  ADDR_W  active-bank read index.
REQ-010 SHALL have port f_weight_o  output  F_WIDTH signed  registered read data.
REQ-011 SHALL have port shadow_full_o  output  1  shadow bank holds DEPTH loaded weights.
REQ-012 SHALL have port active_valid_o  output  1  active bank holds a completed set.
REQ-013 SHALL have port nz_count_o  output  CNT_W  non-zero weights in active bank (only when WBANK_NZ_COUNT_EN is defined).

Function
REQ-014 SHALL hold two banks (active, shadow) of DEPTH signed F_WIDTH registers; ping-pong bank select permitted, behaviour identical to copy.
REQ-015 SHALL run a two-state FSM: LOAD (ld_ready_o=1, shadow_full_o=0) and FULL (ld_ready_o=0, shadow_full_o=1); both outputs registered-state decoded.
REQ-016 SHALL accept a load only on ld_valid_i && ld_ready_o: write shadow[wr_ptr], wr_ptr+1; ld_valid_i while not ready ignored, no data lost beyond sender's hold.
REQ-017 SHALL, on accepting the load with wr_ptr==DEPTH-1, go to FULL on that edge and reset wr_ptr to 0 (no wrap writing into index 0).
REQ-018 SHALL, on swap_i in FULL, on that edge: shadow becomes active, active_valid_o<=1, FSM->LOAD, wr_ptr=0; ld_ready_o high the following cycle.
REQ-019 SHALL ignore swap_i in LOAD, including the same cycle as the final accepted load (swap needs a later cycle).
REQ-020 SHALL update f_weight_o one cycle after rd_addr_i sampling: active[rd_addr_i]; 0 if rd_addr_i>=DEPTH or active_valid_o==0.
REQ-021 SHALL, for a read sampled on the swap edge, return the pre-swap active value; post-swap values from the next sampled address.
REQ-022 SHALL leave new shadow contents stale-but-unobservable after swap; only writes of the new load sequence reach the active side.

Reset
REQ-023 SHALL, with wbank_rst_i high at a clock edge, clear both banks, wr_ptr, f_weight_o, active_valid_o, nz_count_o to 0 and FSM to LOAD; reset dominates loads and swap.
REQ-024 SHALL discard a partial load on reset mid-sequence; ld_ready_o=1 the first cycle after reset deasserts.

Configuration
REQ-025 SHALL, with macro WBANK_NZ_COUNT_EN defined, count non-zero accepted loads into a shadow counter (cleared at wr_ptr=0 start) and transfer it to nz_count_o on the swap edge.
REQ-026 SHALL, without WBANK_NZ_COUNT_EN, omit nz_count_o and the counter; all other behaviour unchanged.

Verification (F_WIDTH=8, DEPTH=9)
REQ-027 SHALL cover: reset, load 1..9 back-to-back, swap, read addr 0..8 -> f_weight_o 1..9, each one cycle after address; shadow_full_o high after 9th load.
REQ-028 SHALL cover: 10th ld_valid_i while FULL (value 0x7F) -> not accepted, ld_ready_o=0; after swap, new load sequence starts at index 0.
REQ-029 SHALL cover: swap_i same cycle as 9th load -> ignored, active_valid_o stays 0; swap next cycle -> active_valid_o=1.
REQ-030 SHALL cover: active={-128,0,0,5,0,0,0,0,127}, load second set 10..18, read addr 3 on swap edge -> 5, next read addr 3 -> 13; rd_addr_i=12 -> 0.
REQ-031 SHALL cover: reset after 4 loads -> wr_ptr 0, outputs 0; a full 9-load sequence then fills indices 0..8.
REQ-032 SHALL cover (WBANK_NZ_COUNT_EN): load {0,3,0,-1,0,0,7,0,0}, swap -> nz_count_o=3; before swap nz_count_o=0.
